// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared sequencer state encoding, instruction field positions, helpers
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  localparam int IR_CBITS_HI = 15;
  localparam int IR_CBITS_LO = 13;
  localparam int IR_DEST_A   = 5;
  localparam int IR_DEST_D   = 4;
  localparam int IR_DEST_M   = 3;
  localparam int IR_JMP_HI   = 2;
  localparam int IR_JMP_LO   = 0;

  localparam logic [2:0] C_PREFIX = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_MEM_WAIT = 3'd3,
    ST_HALT     = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    INSTR_A       = 2'd0,
    INSTR_C       = 2'd1,
    INSTR_ILLEGAL = 2'd2
  } instr_kind_t;

  // Top bit clear is an A-instruction regardless of the two bits below it.
  function automatic instr_kind_t classify(input logic [2:0] cbits);
    if (!cbits[2]) begin
      return INSTR_A;
    end else if (cbits == C_PREFIX) begin
      return INSTR_C;
    end else begin
      return INSTR_ILLEGAL;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_sequencer_jump_cond.sv
// ============================================================================
// jump_cond : combinational jump decision from jump bits and ALU flags
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module jump_cond (
  input  logic [2:0] jbits,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  assign take = (jbits[2] & ng) | (jbits[1] & zr) | (jbits[0] & ~zr & ~ng);

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ============================================================================
// cpu_sequencer : fetch/decode/execute controller with memory handshakes
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MEM_TIMEOUT = 255,
  parameter int HALT_DETECT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_ack,
  input  logic              alu_zr,
  input  logic              alu_ng,
  input  logic [ADDR_W-1:0] a_value,
  input  logic [ADDR_W-1:0] pc_value,
  output logic [DATA_W-1:0] ir,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              a_load,
  output logic              d_load,
  output logic              halted,
  output logic              fault
);

  state_t      state;
  state_t      next_state;
  state_t      after_instr;
  state_t      after_c_instr;
  instr_kind_t kind;
  logic [7:0]  wait_cnt;
  logic        take;
  logic        go_halt;
  logic        c_commit;
  logic        wait_expired;

  jump_cond u_jump_cond (
    .jbits (ir[IR_JMP_HI:IR_JMP_LO]),
    .zr    (alu_zr),
    .ng    (alu_ng),
    .take  (take)
  );

  assign kind    = classify(ir[IR_CBITS_HI:IR_CBITS_LO]);
  assign go_halt = (HALT_DETECT != 0) && take && (a_value == pc_value);

  // A C-instruction retires either straight from DECODE or on the data ack.
  assign c_commit = ((state == ST_DECODE) && (kind == INSTR_C) && !ir[IR_DEST_M]) ||
                    ((state == ST_MEM_WAIT) && dmem_ack);

  assign after_instr   = run ? ST_FETCH : ST_IDLE;
  assign after_c_instr = go_halt ? ST_HALT : after_instr;

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign wait_expired = 1'b0;
    end else begin : g_timeout
      localparam logic [8:0] LIMIT = 9'(MEM_TIMEOUT);
      assign wait_expired = (({1'b0, wait_cnt} + 9'd1) >= LIMIT);
    end
  endgenerate

  always_comb begin
    a_load  = 1'b0;
    d_load  = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    if ((state == ST_DECODE) && (kind == INSTR_A)) begin
      a_load = 1'b1;
      pc_inc = 1'b1;
    end
    if (c_commit) begin
      a_load = ir[IR_DEST_A];
      d_load = ir[IR_DEST_D];
      // A halting jump leaves the PC untouched.
      if (!go_halt) begin
        pc_load = take;
        pc_inc  = ~take;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack)          next_state = ST_DECODE;
        else if (wait_expired) next_state = ST_FAULT;
      end
      ST_DECODE: begin
        case (kind)
          INSTR_A: next_state = after_instr;
          INSTR_C: next_state = ir[IR_DEST_M] ? ST_MEM_WAIT : after_c_instr;
          default: next_state = ST_FAULT;
        endcase
      end
      ST_MEM_WAIT: begin
        if (dmem_ack)          next_state = after_c_instr;
        else if (wait_expired) next_state = ST_FAULT;
      end
      ST_HALT:  next_state = ST_HALT;
      ST_FAULT: next_state = ST_FAULT;
      default:  next_state = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ir       <= '0;
      wait_cnt <= 8'd0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == ST_FETCH) && imem_ack) begin
        ir <= imem_rdata;
      end
      // Staying in a wait state means no ack arrived this cycle.
      if (next_state != state) begin
        wait_cnt <= 8'd0;
      end else if ((state == ST_FETCH) || (state == ST_MEM_WAIT)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      imem_req <= (next_state == ST_FETCH);
      dmem_req <= (next_state == ST_MEM_WAIT);
      dmem_we  <= (next_state == ST_MEM_WAIT);
      halted   <= (next_state == ST_HALT);
      fault    <= (next_state == ST_FAULT);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// tb_cpu_sequencer : randomized instruction-level check of cpu_sequencer
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_sequencer;

  localparam int MT      = 4;
  localparam int S_RUN   = 0;
  localparam int S_IDLE  = 1;
  localparam int S_HALT  = 2;
  localparam int S_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        alu_zr = 1'b0;
  logic        alu_ng = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic [14:0] a_value = 15'h0000;
  logic [14:0] pc_value = 15'h0000;
  logic        imem_req, dmem_req, dmem_we, pc_inc, pc_load, a_load, d_load, halted, fault;
  logic [15:0] ir;

  cpu_sequencer #(
    .ADDR_W(15), .DATA_W(16), .MEM_TIMEOUT(MT), .HALT_DETECT(1)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_zr(alu_zr), .alu_ng(alu_ng), .a_value(a_value), .pc_value(pc_value),
    .ir(ir), .pc_inc(pc_inc), .pc_load(pc_load), .a_load(a_load), .d_load(d_load),
    .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        a_load;
    logic        d_load;
    logic        pc_inc;
    logic        pc_load;
    logic        halted;
    logic        fault;
    logic [15:0] ir;
  } obs_t;

  typedef struct {
    logic a_load;
    logic d_load;
    logic pc_inc;
    logic pc_load;
    logic halt;
    logic illegal;
    logic mem;
  } effect_t;

  obs_t        act;
  obs_t        exp_o = '0;
  logic        exp_valid = 1'b0;
  string       phase = "init";
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_ir = 16'h0000;
  logic        m_halted = 1'b0;
  logic        m_fault = 1'b0;

  assign act = {imem_req, dmem_req, dmem_we, a_load, d_load, pc_inc, pc_load, halted, fault, ir};

  function automatic string fmt(input obs_t o);
    return $sformatf("ireq=%b dreq=%b we=%b ald=%b dld=%b inc=%b ld=%b halt=%b fault=%b ir=%h",
                     o.imem_req, o.dmem_req, o.dmem_we, o.a_load, o.d_load, o.pc_inc,
                     o.pc_load, o.halted, o.fault, o.ir);
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got {%s} expected {%s}", name, $time, fmt(got), fmt(want));
    end
  endtask

  // Instruction semantics: cls 0 = result negative, 1 = zero, 2 = positive.
  function automatic effect_t effect_of(input logic [15:0] i, input int cls,
                                        input logic [14:0] a, input logic [14:0] pc);
    effect_t r;
    bit      take;
    r = '{default: 1'b0};
    if (i[15] == 1'b0) begin
      r.a_load = 1'b1;
      r.pc_inc = 1'b1;
      return r;
    end
    if (i[15:13] != 3'b111) begin
      r.illegal = 1'b1;
      return r;
    end
    r.mem    = i[3];
    r.a_load = i[5];
    r.d_load = i[4];
    case (cls)
      0:       take = i[2];
      1:       take = i[1];
      default: take = i[0];
    endcase
    if (take && (a == pc)) r.halt = 1'b1;
    else if (take)         r.pc_load = 1'b1;
    else                   r.pc_inc = 1'b1;
    return r;
  endfunction

  task automatic check_eff(input string name, input effect_t e, input logic [3:0] want);
    logic [3:0] got;
    got = {e.a_load, e.d_load, e.pc_inc, e.pc_load};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got ald,dld,inc,ld=%b expected %b", name, got, want);
    end
  endtask

  function automatic obs_t base();
    obs_t o;
    o = '0;
    o.ir     = m_ir;
    o.halted = m_halted;
    o.fault  = m_fault;
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic int rcls();
    return int'($urandom_range(0, 2));
  endfunction
  function automatic logic [14:0] r15();
    return 15'($urandom);
  endfunction
  function automatic logic [15:0] r16();
    return 16'($urandom);
  endfunction

  always @(negedge clk) begin
    if (exp_valid) check_obs(phase, act, exp_o);
  end

  task automatic drive(input logic r, input logic iack, input logic [15:0] rd, input logic dack,
                       input int cls, input logic [14:0] a, input logic [14:0] pc, input obs_t e);
    @(posedge clk);
    #1;
    run        = r;
    imem_ack   = iack;
    imem_rdata = rd;
    dmem_ack   = dack;
    alu_ng     = (cls == 0);
    alu_zr     = (cls == 1);
    a_value    = a;
    pc_value   = pc;
    exp_o      = e;
    exp_valid  = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, rnd(), r16(), rnd(), rcls(), r15(), r15(), base());
  endtask

  task automatic hold_cycles(input int n);
    for (int k = 0; k < n; k++) drive(rnd(), rnd(), r16(), rnd(), rcls(), r15(), r15(), base());
  endtask

  task automatic go();
    drive(1'b1, rnd(), r16(), rnd(), rcls(), r15(), r15(), base());
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    exp_valid = 1'b0;
    reset     = 1'b1;
    imem_ack  = 1'b1;
    dmem_ack  = 1'b1;
    m_ir      = 16'h0000;
    m_halted  = 1'b0;
    m_fault   = 1'b0;
    #1;
    check_obs("async_reset", act, base());
    @(posedge clk);
    #1;
    run   = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] instr, input int fw, input int mw,
                           input logic run_after, input int cls, input logic [14:0] a,
                           input logic [14:0] pc, output int status);
    obs_t    e;
    effect_t eff;
    eff = effect_of(instr, cls, a, pc);
    for (int k = 0; k < fw && k < MT; k++) begin
      e = base();
      e.imem_req = 1'b1;
      drive(rnd(), 1'b0, r16(), rnd(), rcls(), r15(), r15(), e);
    end
    if (fw >= MT) begin
      m_fault = 1'b1;
      status = S_FAULT;
      return;
    end
    e = base();
    e.imem_req = 1'b1;
    drive(rnd(), 1'b1, instr, rnd(), rcls(), r15(), r15(), e);
    m_ir = instr;
    e = base();
    if (eff.illegal) begin
      drive(run_after, rnd(), r16(), rnd(), cls, a, pc, e);
      m_fault = 1'b1;
      status = S_FAULT;
      return;
    end
    if (eff.mem) begin
      drive(rnd(), rnd(), r16(), rnd(), rcls(), r15(), r15(), e);
      for (int k = 0; k < mw && k < MT; k++) begin
        e = base();
        e.dmem_req = 1'b1;
        e.dmem_we  = 1'b1;
        drive(rnd(), rnd(), r16(), 1'b0, rcls(), r15(), r15(), e);
      end
      if (mw >= MT) begin
        m_fault = 1'b1;
        status = S_FAULT;
        return;
      end
      e = base();
      e.dmem_req = 1'b1;
      e.dmem_we  = 1'b1;
    end
    e.a_load  = eff.a_load;
    e.d_load  = eff.d_load;
    e.pc_inc  = eff.pc_inc;
    e.pc_load = eff.pc_load;
    drive(run_after, rnd(), r16(), eff.mem ? 1'b1 : rnd(), cls, a, pc, e);
    if (eff.halt) begin
      m_halted = 1'b1;
      status = S_HALT;
    end else begin
      status = run_after ? S_RUN : S_IDLE;
    end
  endtask

  initial begin
    int          st;
    int          pick;
    logic [15:0] instr;
    logic [14:0] ra;
    obs_t        e;

    repeat (2) @(posedge clk);
    #1;
    check_obs("reset_state", act, base());
    reset = 1'b0;

    check_eff("model_a_instr", effect_of(16'h0005, 2, 15'h0001, 15'h0002), 4'b1010);
    check_eff("model_jmp", effect_of(16'hE307, 2, 15'h0100, 15'h0050), 4'b0001);
    check_eff("model_jlt_pos", effect_of(16'hE304, 2, 15'h0100, 15'h0050), 4'b0010);
    check_eff("model_jlt_neg", effect_of(16'hE304, 0, 15'h0100, 15'h0050), 4'b0001);
    check_eff("model_jgt_zero", effect_of(16'hE301, 1, 15'h0100, 15'h0050), 4'b0010);
    check_eff("model_dest_ad", effect_of(16'hE330, 2, 15'h0100, 15'h0050), 4'b1110);

    phase = "directed_seq";
    idle_cycles(2);
    go();
    run_instr(16'h0005, 2, 0, 1'b1, 2, 15'h0100, 15'h0050, st);
    run_instr(16'hE307, 0, 0, 1'b1, 2, 15'h0100, 15'h0050, st);
    run_instr(16'hE304, 1, 0, 1'b1, 2, 15'h0100, 15'h0050, st);
    run_instr(16'hE304, 0, 0, 1'b1, 0, 15'h0100, 15'h0050, st);
    run_instr(16'hE301, 3, 0, 1'b1, 1, 15'h0100, 15'h0050, st);
    run_instr(16'hE308, 0, 3, 1'b1, 2, 15'h0100, 15'h0050, st);
    run_instr(16'hE33F, 3, 3, 1'b0, 0, 15'h0100, 15'h0050, st);
    idle_cycles(3);

    phase = "fetch_timeout";
    go();
    run_instr(16'h0005, MT, 0, 1'b1, 2, 15'h0000, 15'h0001, st);
    hold_cycles(3);
    do_reset();
    idle_cycles(2);

    phase = "mem_timeout";
    go();
    run_instr(16'hE308, 1, MT, 1'b1, 2, 15'h0000, 15'h0001, st);
    hold_cycles(3);
    do_reset();

    phase = "halt";
    go();
    run_instr(16'hE307, 0, 0, 1'b1, 2, 15'h0010, 15'h0010, st);
    hold_cycles(5);
    do_reset();
    idle_cycles(2);

    phase = "illegal";
    go();
    run_instr(16'hA000, 0, 0, 1'b1, 2, 15'h0000, 15'h0001, st);
    hold_cycles(2);
    do_reset();

    phase = "reset_mid_fetch";
    go();
    e = base();
    e.imem_req = 1'b1;
    drive(1'b1, 1'b0, r16(), 1'b0, 2, r15(), r15(), e);
    do_reset();
    idle_cycles(3);

    phase = "random";
    go();
    for (int n = 0; n < 400; n++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 40)      instr = {1'b0, r15()};
      else if (pick < 95) instr = {3'b111, 13'($urandom)};
      else                instr = {1'b1, 2'($urandom_range(0, 2)), 13'($urandom)};
      ra = r15();
      run_instr(instr, int'($urandom_range(0, MT - 1)), int'($urandom_range(0, MT - 1)),
                ($urandom_range(0, 9) != 0), rcls(), ra,
                ($urandom_range(0, 5) == 0) ? ra : r15(), st);
      if (st == S_IDLE) begin
        idle_cycles(int'($urandom_range(0, 3)));
        go();
      end else if (st != S_RUN) begin
        hold_cycles(2);
        do_reset();
        go();
      end
    end

    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
